// File: rtl/floo_eoc_pkg.sv
// Shared types and constants for the FlooNoC end-of-computation monitor.
// State encoding is exported on state_o, so the values are fixed.
package floo_eoc_pkg;

  typedef enum logic [2:0] {
    EocIdle    = 3'd0,
    EocRun     = 3'd1,
    EocDrain   = 3'd2,
    EocDone    = 3'd3,
    EocTimeout = 3'd4
  } eoc_state_e;

  localparam int unsigned DefaultDrainCycles   = 100;
  localparam int unsigned DefaultTimeoutCycles = 1000000;

  // Bit offset of tile t inside the flattened per-core flag vector.
  function automatic int unsigned tile_slice(input int unsigned t, input int unsigned num_cores);
    return t * num_cores;
  endfunction

endpackage

// File: rtl/floo_eoc_tile_tracker.sv
// Per-tile sticky capture of core end-of-sim flags; tile_done is the registered view,
// tile_done_next folds in the current flags so the FSM can react in the same cycle.
module floo_eoc_tile_tracker #(
  parameter int unsigned NumCores = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                capture,
  input  logic [NumCores-1:0] eos,
  output logic                tile_done,
  output logic                tile_done_next
);

  logic [NumCores-1:0] sticky;

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky <= '0;
    end else if (capture) begin
      sticky <= sticky | eos;
    end
  end

  assign tile_done      = &sticky;
  assign tile_done_next = &(sticky | eos);

endmodule

// File: rtl/floo_eoc_monitor.sv
// End-of-computation monitor: latches per-core completion, waits for a NoC drain period,
// then reports done; a watchdog reports timeout instead. done_o/timeout_o lag the state by one cycle.
module floo_eoc_monitor
  import floo_eoc_pkg::*;
#(
  parameter int unsigned NumTiles      = 4,
  parameter int unsigned NumCores      = 9,
  parameter int unsigned DrainCycles   = DefaultDrainCycles,
  parameter int unsigned TimeoutCycles = DefaultTimeoutCycles,
  parameter int unsigned CntWidth      = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         en_i,
  input  logic [NumTiles-1:0]          tile_mask_i,
  input  logic [NumTiles*NumCores-1:0] core_eos_i,
  input  logic                         noc_idle_i,
  output logic [NumTiles-1:0]          tiles_done_o,
  output logic [2:0]                   state_o,
  output logic                         done_o,
  output logic                         timeout_o,
  output logic [CntWidth-1:0]          elapsed_o
);

  if (NumTiles == 0 || NumCores == 0) begin : g_bad_dims
    $error("floo_eoc_monitor: NumTiles and NumCores must be at least 1");
  end
  if (CntWidth == 0 ||
      (CntWidth < 32 && ((DrainCycles >> CntWidth) != 0 || (TimeoutCycles >> CntWidth) != 0)))
  begin : g_bad_width
    $error("floo_eoc_monitor: DrainCycles/TimeoutCycles do not fit in CntWidth");
  end

  localparam logic [CntWidth-1:0] DrainLast   = CntWidth'(DrainCycles == 0 ? 0 : DrainCycles - 1);
  localparam logic [CntWidth-1:0] TimeoutLast = CntWidth'(TimeoutCycles == 0 ? 0 : TimeoutCycles - 1);
  localparam logic [CntWidth-1:0] CntMax      = '1;

  eoc_state_e          state;
  logic [CntWidth-1:0] drain_cnt;
  logic [CntWidth-1:0] elapsed;
  logic [NumTiles-1:0] tile_done_next;
  logic [NumTiles-1:0] tiles_done;
  logic                done;
  logic                timeout;
  logic                capture;
  logic                active;
  logic                all_done;
  logic                wd_expire;
  logic                drain_last;

  assign capture = (state != EocIdle);
  assign active  = (state == EocRun) || (state == EocDrain);

  for (genvar t = 0; t < NumTiles; t++) begin : g_tile
    floo_eoc_tile_tracker #(
      .NumCores(NumCores)
    ) u_tracker (
      .clk           (clk_i),
      .rst           (rst_i),
      .capture       (capture),
      .eos           (core_eos_i[tile_slice(t, NumCores) +: NumCores]),
      .tile_done     (tiles_done[t]),
      .tile_done_next(tile_done_next[t])
    );
  end

  // Masked-off tiles count as finished; an empty mask completes vacuously.
  assign all_done   = &(~tile_mask_i | tile_done_next);
  assign wd_expire  = (TimeoutCycles != 0) && en_i && (elapsed == TimeoutLast);
  assign drain_last = en_i && noc_idle_i && (drain_cnt == DrainLast);

  // Completion is checked ahead of the watchdog so a same-edge DONE wins,
  // while RUN->DRAIN yields to the watchdog.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= EocIdle;
      done    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      done    <= (state == EocDone);
      timeout <= (state == EocTimeout);
      case (state)
        EocIdle: begin
          if (en_i) state <= EocRun;
        end
        EocRun: begin
          if (en_i && all_done && DrainCycles == 0) state <= EocDone;
          else if (wd_expire)                       state <= EocTimeout;
          else if (en_i && all_done)                state <= EocDrain;
        end
        EocDrain: begin
          if (drain_last)     state <= EocDone;
          else if (wd_expire) state <= EocTimeout;
        end
        default: state <= state;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drain_cnt <= '0;
    end else if (state != EocDrain || !noc_idle_i) begin
      drain_cnt <= '0;
    end else if (en_i) begin
      drain_cnt <= drain_cnt + CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      elapsed <= '0;
    end else if (en_i && active && elapsed != CntMax) begin
      elapsed <= elapsed + CntWidth'(1);
    end
  end

  assign tiles_done_o = tiles_done;
  assign state_o      = state;
  assign done_o       = done;
  assign timeout_o    = timeout;
  assign elapsed_o    = elapsed;

endmodule

// File: tb/tb_floo_eoc_monitor.sv
// Self-checking bench for floo_eoc_monitor: four parameterisations share one stimulus bus.
module tb_floo_eoc_monitor;

  localparam int NT = 4;
  localparam int NC = 9;
  localparam int CW = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             noc_idle;
  logic [NT-1:0]    mask;
  logic [NT*NC-1:0] eos;

  logic [NT-1:0] dflt_tiles, to_tiles, d0_tiles, d5_tiles;
  logic [2:0]    dflt_state, to_state, d0_state, d5_state;
  logic          dflt_done, to_done, d0_done, d5_done;
  logic          dflt_tmo, to_tmo, d0_tmo, d5_tmo;
  logic [CW-1:0] dflt_el, to_el, d0_el, d5_el;

  always #5 clk = ~clk;

  floo_eoc_monitor u_dflt (
    .clk_i(clk), .rst_i(rst), .en_i(en), .tile_mask_i(mask), .core_eos_i(eos),
    .noc_idle_i(noc_idle), .tiles_done_o(dflt_tiles), .state_o(dflt_state),
    .done_o(dflt_done), .timeout_o(dflt_tmo), .elapsed_o(dflt_el)
  );

  floo_eoc_monitor #(.TimeoutCycles(200)) u_to (
    .clk_i(clk), .rst_i(rst), .en_i(en), .tile_mask_i(mask), .core_eos_i(eos),
    .noc_idle_i(noc_idle), .tiles_done_o(to_tiles), .state_o(to_state),
    .done_o(to_done), .timeout_o(to_tmo), .elapsed_o(to_el)
  );

  floo_eoc_monitor #(.DrainCycles(0), .TimeoutCycles(20)) u_d0 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .tile_mask_i(mask), .core_eos_i(eos),
    .noc_idle_i(noc_idle), .tiles_done_o(d0_tiles), .state_o(d0_state),
    .done_o(d0_done), .timeout_o(d0_tmo), .elapsed_o(d0_el)
  );

  floo_eoc_monitor #(.DrainCycles(5), .TimeoutCycles(20)) u_d5 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .tile_mask_i(mask), .core_eos_i(eos),
    .noc_idle_i(noc_idle), .tiles_done_o(d5_tiles), .state_o(d5_state),
    .done_o(d5_done), .timeout_o(d5_tmo), .elapsed_o(d5_el)
  );

  typedef struct {
    string      name;
    int         inst;
    logic [2:0] state;
    logic       done;
    logic       tmo;
    int         lat;
    int         elapsed;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic exp_t mk(input string n, input int inst, input logic [2:0] s,
                              input logic d, input logic t, input int lat, input int el);
    exp_t e;
    e.name = n; e.inst = inst; e.state = s; e.done = d; e.tmo = t; e.lat = lat; e.elapsed = el;
    return e;
  endfunction

  function automatic logic [2:0] st_of(input int inst);
    case (inst)
      0: return dflt_state;
      1: return to_state;
      2: return d0_state;
      default: return d5_state;
    endcase
  endfunction

  function automatic logic [1:0] flags_of(input int inst);
    case (inst)
      0: return {dflt_done, dflt_tmo};
      1: return {to_done, to_tmo};
      2: return {d0_done, d0_tmo};
      default: return {d5_done, d5_tmo};
    endcase
  endfunction

  function automatic int el_of(input int inst);
    case (inst)
      0: return int'(dflt_el);
      1: return int'(to_el);
      2: return int'(d0_el);
      default: return int'(d5_el);
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; eos = '0; noc_idle = 1'b1; mask = '1;
    step();
    rst = 1'b0;
  endtask

  task automatic pulse_tile(input int t);
    eos = '0;
    eos[t*NC +: NC] = '1;
    step();
    eos = '0;
  endtask

  task automatic wait_flag(input int inst, input int budget, output int lat, output bit expired);
    lat = 0;
    expired = 1'b1;
    for (int i = 0; i < budget; i++) begin
      step();
      lat++;
      if (flags_of(inst) != 2'b00) begin
        expired = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (dflt_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", dflt_state); end
    checks++; if ({dflt_done, dflt_tmo} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {dflt_done, dflt_tmo}); end
    checks++; if (dflt_el !== '0) begin errors++; $display("FAIL reset_elapsed: got %0d expected 0", dflt_el); end
    checks++; if (dflt_tiles !== '0) begin errors++; $display("FAIL reset_tiles: got %h expected 0", dflt_tiles); end
  endtask

  task automatic test_full_completion();
    int lat; bit exp_out; exp_t e;
    do_reset();
    en = 1'b1;
    step();
    checks++; if (dflt_state !== 3'd1) begin errors++; $display("FAIL full_run: got %0d expected 1", dflt_state); end
    for (int t = 0; t < NT; t++) begin
      pulse_tile(t);
      checks++;
      if (dflt_tiles !== NT'((1 << (t + 1)) - 1)) begin
        errors++; $display("FAIL full_tiles%0d: got %h expected %h", t, dflt_tiles, NT'((1 << (t + 1)) - 1));
      end
    end
    checks++; if (dflt_state !== 3'd2) begin errors++; $display("FAIL full_drain_entry: got %0d expected 2", dflt_state); end
    sb.push_back(mk("full", 0, 3'd3, 1'b1, 1'b0, 101, 104));
    wait_flag(0, 300, lat, exp_out);
    e = sb.pop_front();
    checks++; if (exp_out || lat != e.lat) begin errors++; $display("FAIL %s_lat: got %0d (expired=%0d) expected %0d", e.name, lat, exp_out, e.lat); end
    checks++; if ({st_of(e.inst), flags_of(e.inst)} !== {e.state, e.done, e.tmo}) begin errors++; $display("FAIL %s_state: got %0d/%b expected %0d/%b", e.name, st_of(e.inst), flags_of(e.inst), e.state, {e.done, e.tmo}); end
    checks++; if (el_of(e.inst) != e.elapsed) begin errors++; $display("FAIL %s_elapsed: got %0d expected %0d", e.name, el_of(e.inst), e.elapsed); end
    repeat (5) step();
    checks++; if (dflt_el !== 32'd104 || dflt_tiles !== 4'hF) begin errors++; $display("FAIL full_frozen: got el=%0d tiles=%h expected 104/f", dflt_el, dflt_tiles); end
  endtask

  task automatic test_mask();
    int lat; bit exp_out; exp_t e;
    do_reset();
    mask = 4'b0101; en = 1'b1;
    step();
    pulse_tile(0);
    pulse_tile(2);
    checks++; if (dflt_state !== 3'd2) begin errors++; $display("FAIL mask_drain_entry: got %0d expected 2", dflt_state); end
    sb.push_back(mk("mask", 0, 3'd3, 1'b1, 1'b0, 101, 102));
    wait_flag(0, 300, lat, exp_out);
    e = sb.pop_front();
    checks++; if (exp_out || lat != e.lat) begin errors++; $display("FAIL %s_lat: got %0d (expired=%0d) expected %0d", e.name, lat, exp_out, e.lat); end
    checks++; if ({st_of(e.inst), flags_of(e.inst)} !== {e.state, e.done, e.tmo}) begin errors++; $display("FAIL %s_state: got %0d/%b expected %0d/%b", e.name, st_of(e.inst), flags_of(e.inst), e.state, {e.done, e.tmo}); end
    checks++; if (el_of(e.inst) != e.elapsed) begin errors++; $display("FAIL %s_elapsed: got %0d expected %0d", e.name, el_of(e.inst), e.elapsed); end
    checks++; if (dflt_tiles !== 4'b0101) begin errors++; $display("FAIL mask_tiles: got %b expected 0101", dflt_tiles); end
    do_reset();
    mask = 4'b0000; en = 1'b1;
    step();
    checks++; if (dflt_state !== 3'd1) begin errors++; $display("FAIL empty_mask_run: got %0d expected 1", dflt_state); end
    step();
    checks++; if (dflt_state !== 3'd2 || dflt_tiles !== 4'b0000) begin errors++; $display("FAIL empty_mask_drain: got %0d/%b expected 2/0000", dflt_state, dflt_tiles); end
  endtask

  task automatic test_drain_restart();
    int lat; bit exp_out; exp_t e;
    do_reset();
    en = 1'b1;
    step();
    eos = '1;
    step();
    eos = '0;
    checks++; if (dflt_state !== 3'd2) begin errors++; $display("FAIL restart_entry: got %0d expected 2", dflt_state); end
    repeat (50) step();
    noc_idle = 1'b0;
    step();
    noc_idle = 1'b1;
    checks++; if (dflt_state !== 3'd2) begin errors++; $display("FAIL restart_still_drain: got %0d expected 2", dflt_state); end
    sb.push_back(mk("restart", 0, 3'd3, 1'b1, 1'b0, 101, 152));
    wait_flag(0, 300, lat, exp_out);
    e = sb.pop_front();
    checks++; if (exp_out || lat != e.lat) begin errors++; $display("FAIL %s_lat: got %0d (expired=%0d) expected %0d", e.name, lat, exp_out, e.lat); end
    checks++; if ({st_of(e.inst), flags_of(e.inst)} !== {e.state, e.done, e.tmo}) begin errors++; $display("FAIL %s_state: got %0d/%b expected %0d/%b", e.name, st_of(e.inst), flags_of(e.inst), e.state, {e.done, e.tmo}); end
    checks++; if (el_of(e.inst) != e.elapsed) begin errors++; $display("FAIL %s_elapsed: got %0d expected %0d", e.name, el_of(e.inst), e.elapsed); end
  endtask

  task automatic test_timeout();
    int lat; bit exp_out; exp_t e;
    do_reset();
    en = 1'b1;
    step();
    for (int t = 0; t < 3; t++) pulse_tile(t);
    sb.push_back(mk("timeout", 1, 3'd4, 1'b0, 1'b1, 198, 200));
    wait_flag(1, 400, lat, exp_out);
    e = sb.pop_front();
    checks++; if (exp_out || lat != e.lat) begin errors++; $display("FAIL %s_lat: got %0d (expired=%0d) expected %0d", e.name, lat, exp_out, e.lat); end
    checks++; if ({st_of(e.inst), flags_of(e.inst)} !== {e.state, e.done, e.tmo}) begin errors++; $display("FAIL %s_state: got %0d/%b expected %0d/%b", e.name, st_of(e.inst), flags_of(e.inst), e.state, {e.done, e.tmo}); end
    checks++; if (el_of(e.inst) != e.elapsed) begin errors++; $display("FAIL %s_elapsed: got %0d expected %0d", e.name, el_of(e.inst), e.elapsed); end
    pulse_tile(3);
    repeat (3) step();
    checks++; if ({to_state, to_done, to_tmo} !== {3'd4, 1'b0, 1'b1}) begin errors++; $display("FAIL timeout_terminal: got %0d/%b expected 4/01", to_state, {to_done, to_tmo}); end
  endtask

  task automatic test_same_edge();
    int lat; bit exp_out; exp_t e;
    do_reset();
    en = 1'b1;
    step();
    for (int t = 0; t < 3; t++) pulse_tile(t);
    repeat (16) step();
    checks++; if (d0_state !== 3'd1 || d5_state !== 3'd1) begin errors++; $display("FAIL same_edge_pre: got %0d/%0d expected 1/1", d0_state, d5_state); end
    pulse_tile(3);
    sb.push_back(mk("same_d0", 2, 3'd3, 1'b1, 1'b0, 1, 20));
    sb.push_back(mk("same_d5", 3, 3'd4, 1'b0, 1'b1, 1, 20));
    wait_flag(2, 10, lat, exp_out);
    for (int k = 0; k < 2; k++) begin
      e = sb.pop_front();
      checks++; if (exp_out || lat != e.lat) begin errors++; $display("FAIL %s_lat: got %0d (expired=%0d) expected %0d", e.name, lat, exp_out, e.lat); end
      checks++; if ({st_of(e.inst), flags_of(e.inst)} !== {e.state, e.done, e.tmo}) begin errors++; $display("FAIL %s_state: got %0d/%b expected %0d/%b", e.name, st_of(e.inst), flags_of(e.inst), e.state, {e.done, e.tmo}); end
      checks++; if (el_of(e.inst) != e.elapsed) begin errors++; $display("FAIL %s_elapsed: got %0d expected %0d", e.name, el_of(e.inst), e.elapsed); end
    end
  endtask

  task automatic test_enable_pause();
    do_reset();
    en = 1'b1;
    step();
    pulse_tile(0);
    en = 1'b0;
    for (int i = 0; i < 30; i++) begin
      eos = '0;
      if (i == 5)  eos[1*NC +: NC] = '1;
      if (i == 10) eos[2*NC +: NC] = '1;
      if (i == 15) eos[3*NC +: NC] = '1;
      step();
    end
    eos = '0;
    checks++; if (dflt_el !== 32'd1 || dflt_state !== 3'd1) begin errors++; $display("FAIL pause_hold: got el=%0d st=%0d expected 1/1", dflt_el, dflt_state); end
    checks++; if (dflt_tiles !== 4'hF) begin errors++; $display("FAIL pause_capture: got %h expected f", dflt_tiles); end
    en = 1'b1;
    step();
    checks++; if (dflt_state !== 3'd2 || dflt_el !== 32'd2) begin errors++; $display("FAIL pause_resume: got st=%0d el=%0d expected 2/2", dflt_state, dflt_el); end
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (dflt_state !== 3'd0 || {dflt_done, dflt_tmo} !== 2'b00) begin errors++; $display("FAIL midreset_state: got %0d/%b expected 0/00", dflt_state, {dflt_done, dflt_tmo}); end
    checks++; if (dflt_el !== '0 || dflt_tiles !== '0) begin errors++; $display("FAIL midreset_counts: got el=%0d tiles=%h expected 0/0", dflt_el, dflt_tiles); end
  endtask

  initial begin
    test_reset();
    test_full_completion();
    test_mask();
    test_drain_restart();
    test_timeout();
    test_same_edge();
    test_enable_pause();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/floo_eoc_monitor.md
Name: floo_eoc_monitor

Overview:
Synthesizable end-of-computation monitor for FlooNoC compute-tile arrays. It replaces fixed-size, hierarchical end-of-sim probing with a parametrised block that takes per-core end-of-sim flags from NumTiles tiles. It latches completion per core and supports per-tile masking. After all unmasked tiles finish it waits for a configurable NoC drain period, then reports done. A watchdog reports timeout instead if completion or drain never happens. It sits beside the compute tile array and is shared by testbenches and the SoC status path.

Parameters:
NumTiles, 4, number of compute tiles monitored
NumCores, 9, end-of-sim flags per tile
DrainCycles, 100, cycles noc_idle_i must stay high after completion before done; 0 skips drain
TimeoutCycles, 1000000, watchdog limit in enabled RUN/DRAIN cycles; 0 disables watchdog
CntWidth, 32, width of elapsed and drain counters

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
en_i  in  1  monitor enable; low pauses counters
tile_mask_i  in  NumTiles  1 = tile participates; 0 = tile treated as done
core_eos_i  in  NumTiles*NumCores  per-core end-of-sim pulse or level; tile t owns bits [t*NumCores +: NumCores]
noc_idle_i  in  1  NoC has no outstanding transactions
tiles_done_o  out  NumTiles  per-tile sticky completion
state_o  out  3  encoded FSM state
done_o  out  1  sticky, completion plus drain finished
timeout_o  out  1  sticky, watchdog expired
elapsed_o  out  CntWidth  enabled cycles spent in RUN+DRAIN, saturating

Behaviour:
- Reset is synchronous and active-high: all sticky bits 0, state IDLE, done_o=0, timeout_o=0, elapsed_o=0, tiles_done_o=0, drain counter 0. Reset asserted mid-operation clears everything on the next edge.
- Sticky capture:
  - core_sticky[i] <= core_sticky[i] | core_eos_i[i]. Capture is active in every state except IDLE, regardless of en_i.
  - A 1-cycle pulse is enough.
  - Sticky bits never clear except on reset.
- tiles_done_o[t] = AND of that tile's core_sticky bits (registered view).
- all_done is combinational: AND over t of (~tile_mask_i[t] | AND(core_sticky | core_eos_i) for tile t). This allows a same-cycle transition.
- An all-zero mask means all_done=1 (vacuous).
- FSM states: IDLE=0, RUN=1, DRAIN=2, DONE=3, TIMEOUT=4.
  - IDLE -> RUN when en_i=1.
  - RUN, en_i=1, all_done=1 -> DRAIN, or -> DONE directly if DrainCycles=0.
  - DRAIN: drain_cnt increments each cycle where en_i & noc_idle_i; it clears to 0 on any cycle with noc_idle_i=0.
  - DRAIN -> DONE on the edge where drain_cnt==DrainCycles-1, noc_idle_i=1 and en_i=1. With constant idle, DRAIN lasts exactly DrainCycles cycles.
  - RUN/DRAIN -> TIMEOUT when TimeoutCycles!=0 and elapsed reaches TimeoutCycles-1 with en_i=1.
  - DONE and TIMEOUT are terminal until reset.
- Priority: if the completion-to-DONE (or RUN->DONE) condition and the timeout condition occur on the same edge, DONE wins. If RUN->DRAIN and timeout occur on the same edge, TIMEOUT wins.
- en_i=0 in RUN/DRAIN:
  - state, elapsed and drain_cnt hold;
  - sticky capture continues;
  - noc_idle_i=0 still clears drain_cnt.
- elapsed_o increments once per cycle in RUN/DRAIN with en_i=1 and saturates at 2^CntWidth-1.
- done_o = (state==DONE); timeout_o = (state==TIMEOUT). Both are registered state decodes, so they are valid the cycle after the transition edge.
- tile_mask_i changes are honoured live while in RUN. Masking a tile off can trigger completion.
- Elaboration checks: NumTiles>=1, NumCores>=1, DrainCycles and TimeoutCycles must fit in CntWidth.

Decomposition:
- Package floo_eoc_pkg holds:
  - the eoc_state_e enum (3-bit encoding above);
  - the default DrainCycles and TimeoutCycles constants;
  - a helper function tile_slice(t) returning the bit offset.
- Sub-module floo_eoc_tile_tracker, instantiated NumTiles times:
  - NumCores sticky bits;
  - outputs the registered tile_done and the combinational tile_done_next (sticky|eos AND).
- Top level holds the FSM, drain counter, elapsed counter and watchdog.

Test Plan:
- Defaults, en_i=1, noc_idle_i=1; pulse all 36 eos bits, one tile per cycle at cycles 10..13 -> DRAIN entered at edge 13, done_o high 101 cycles later, elapsed_o=104 frozen, tiles_done_o=4'hF.
- tile_mask_i=4'b0101; only tiles 0 and 2 complete -> done_o asserted after drain. Separately, with mask 4'b0000 -> DRAIN entered on the first enabled cycle.
- During DRAIN, drop noc_idle_i for 1 cycle at drain_cnt=50 -> drain restarts; done_o arrives 100 cycles after idle returns.
- TimeoutCycles=200, tile 3 never completes -> timeout_o rises after 200 enabled cycles, done_o stays 0. Later eos pulses for tile 3 -> no change to state.
- DrainCycles=0, TimeoutCycles=20; last eos and the watchdog expiry on the same edge -> state DONE, timeout_o=0. Repeat with DrainCycles=5 -> state TIMEOUT.
- en_i low for 30 cycles mid-RUN while eos pulses arrive -> elapsed_o holds, sticky bits captured, completion on re-enable. Assert rst_i mid-DRAIN -> all outputs 0, state IDLE next cycle.
